// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Imported by add_sub_stage and pipelined_add_sub.
package add_sub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
    function automatic logic signed_overflow(input logic carry_into_msb,
                                             input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/add_sub_stage.sv
// One carry-chain slice of the pipelined adder: adds SW bits at LSB and registers
// the slice result, its carry and the operand/result payload for the next slice.
module add_sub_stage
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 16,
    parameter int LSB   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    output logic             valid_q,
    output logic             carry_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] res_q
);

    logic             valid_d;
    logic             carry_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic [SW-1:0]    slice_sum;
    logic             data_en;

    always_comb begin
        {carry_d, slice_sum} = {1'b0, a_in[LSB +: SW]} + {1'b0, b_in[LSB +: SW]}
                             + {{SW{1'b0}}, carry_in};
        res_d              = res_in;
        res_d[LSB +: SW]   = slice_sum;
        a_d                = a_in;
        b_d                = b_in;
        valid_d            = load_en ? valid_in : valid_q;
        // Payload only moves with a real transaction so a stalled result stays put.
        data_en            = load_en && valid_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (data_en) begin
                carry_q <= carry_d;
                a_q     <= a_d;
                b_q     <= b_d;
                res_q   <= res_d;
            end
        end
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub with valid/ready flow control and carry/overflow flags.
// Define ADD_SUB_SATURATE_EN to clamp overflowing results to the signed extreme.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;

    mode_e             mode_op;
    logic [WIDTH-1:0]  b_eff;
    logic              carry_in0;

    logic [STAGES-1:0] load_en;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];

    logic [WIDTH-1:0]  res_w;
    logic [WIDTH-1:0]  a_last;
    logic [WIDTH-1:0]  b_last;
    logic              carry_into_msb;
    logic              ovf;
    logic              unused_low_operands;

    // Subtract is a + ~b + 1, the +1 entering as the carry-in of slice 0.
    always_comb begin
        mode_op   = mode_e'(mode);
        b_eff     = (mode_op == MODE_SUB) ? ~b : b;
        carry_in0 = (mode_op == MODE_SUB);
    end

    // Bubble-collapsing: a stage loads when it is empty or its successor is loading.
    always_comb begin
        logic downstream;
        load_en    = '0;
        downstream = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load_en[k] = !valid_q[k] || downstream;
            downstream = load_en[k];
        end
    end

    assign in_ready = load_en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            add_sub_stage #(
                .WIDTH (WIDTH),
                .SW    (SW),
                .LSB   (0)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .load_en  (load_en[0]),
                .valid_in (in_valid),
                .carry_in (carry_in0),
                .a_in     (a),
                .b_in     (b_eff),
                .res_in   ('0),
                .valid_q  (valid_q[0]),
                .carry_q  (carry_q[0]),
                .a_q      (a_q[0]),
                .b_q      (b_q[0]),
                .res_q    (res_q[0])
            );
        end else begin : g_next
            add_sub_stage #(
                .WIDTH (WIDTH),
                .SW    (SW),
                .LSB   (k * SW)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .load_en  (load_en[k]),
                .valid_in (valid_q[k-1]),
                .carry_in (carry_q[k-1]),
                .a_in     (a_q[k-1]),
                .b_in     (b_q[k-1]),
                .res_in   (res_q[k-1]),
                .valid_q  (valid_q[k]),
                .carry_q  (carry_q[k]),
                .a_q      (a_q[k]),
                .b_q      (b_q[k]),
                .res_q    (res_q[k])
            );
        end
    end

    // The MSB sum bit is a^b^cin, so the carry into the MSB is recovered from the final payload.
    always_comb begin
        res_w          = res_q[STAGES-1];
        a_last         = a_q[STAGES-1];
        b_last         = b_q[STAGES-1];
        carry_into_msb = a_last[WIDTH-1] ^ b_last[WIDTH-1] ^ res_w[WIDTH-1];
        ovf            = signed_overflow(carry_into_msb, carry_q[STAGES-1]);
    end

    assign unused_low_operands = ^{a_last[WIDTH-2:0], b_last[WIDTH-2:0]};

`ifdef ADD_SUB_SATURATE_EN
    // On overflow the true result has A's sign, so clamp toward that extreme.
    always_comb begin
        sum = res_w;
        if (ovf) begin
            sum = a_last[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = res_w;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];
    assign overflow  = ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed vectors, back-pressure,
// reset mid-flight and randomized sweeps over three WIDTH/STAGES configurations.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct {
        logic        m;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv  [3];
    logic        ordy[3];
    logic        md  [3];
    logic [63:0] a_s [3];
    logic [63:0] b_s [3];

    logic        ir_s [3];
    logic        ov_s [3];
    logic        co_s [3];
    logic        of_s [3];
    logic [63:0] sum_s[3];

    logic        ir0, ov0, co0, of0;
    logic [31:0] s0;
    logic        ir1, ov1, co1, of1;
    logic [7:0]  s1;
    logic        ir2, ov2, co2, of2;
    logic [63:0] s2;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_add_sub #(.WIDTH(32), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .mode(md[0]),
        .a(a_s[0][31:0]), .b(b_s[0][31:0]), .out_valid(ov0), .out_ready(ordy[0]),
        .sum(s0), .carry_out(co0), .overflow(of0));

    pipelined_add_sub #(.WIDTH(8), .STAGES(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .mode(md[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .out_valid(ov1), .out_ready(ordy[1]),
        .sum(s1), .carry_out(co1), .overflow(of1));

    pipelined_add_sub #(.WIDTH(64), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .mode(md[2]),
        .a(a_s[2]), .b(b_s[2]), .out_valid(ov2), .out_ready(ordy[2]),
        .sum(s2), .carry_out(co2), .overflow(of2));

    always_comb begin
        ir_s[0] = ir0; ov_s[0] = ov0; co_s[0] = co0; of_s[0] = of0; sum_s[0] = {32'b0, s0};
        ir_s[1] = ir1; ov_s[1] = ov1; co_s[1] = co1; of_s[1] = of1; sum_s[1] = {56'b0, s1};
        ir_s[2] = ir2; ov_s[2] = ov2; co_s[2] = co2; of_s[2] = of2; sum_s[2] = s2;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands, signed range test for overflow.
    function automatic res_t ref_model(input int w, input logic m,
                                       input logic [63:0] a, input logic [63:0] b);
        res_t r;
        logic [129:0]        ua, ub, full, pw_u;
        logic signed [129:0] sa, sb, t, pw, hi, lo;
        logic [63:0]         mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = {66'd0, a & mask};
        ub   = {66'd0, b & mask};
        pw_u = 130'd1 << w;
        pw   = pw_u;
        full = m ? (ua + (pw_u - ub)) : (ua + ub);
        r.s  = full[63:0] & mask;
        if (m) r.c = (ua >= ub);
        else   r.c = ((ua + ub) >> w) != 130'd0;
        sa = ua; if (ua[w-1]) sa = sa - pw;
        sb = ub; if (ub[w-1]) sb = sb - pw;
        t  = m ? (sa - sb) : (sa + sb);
        hi = (pw >>> 1) - 1;
        lo = -(pw >>> 1);
        r.o = (t > hi) || (t < lo);
`ifdef ADD_SUB_SATURATE_EN
        if (r.o) r.s = ua[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
        return r;
    endfunction

    function automatic logic [63:0] pick_operand(input logic [63:0] mask);
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return mask >> 1;
            1:       return (mask >> 1) + 64'd1;
            2:       return mask;
            3:       return 64'd0;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; md[d] = 1'b0; a_s[d] = '0; b_s[d] = '0;
        end
    endtask

    // Single transaction on dut0 with out_ready high; checks latency and result fields.
    task automatic send_one(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        iv[0] = 1'b1; md[0] = v.m; a_s[0] = v.a; b_s[0] = v.b; ordy[0] = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), {63'd0, ir_s[0]}, 64'd1);
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 1;
        #1;
        while (!ov_s[0] && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
        chk($sformatf("vec%0d_sum", idx), sum_s[0], v.s);
        chk($sformatf("vec%0d_carry", idx), {63'd0, co_s[0]}, {63'd0, v.c});
        chk($sformatf("vec%0d_ovf", idx), {63'd0, of_s[0]}, {63'd0, v.o});
    endtask

    task automatic run_random(input int d, input int w, input int stages,
                              input int ncyc, input bit full_rate);
        res_t        exp_q[$];
        int          t_q[$];
        res_t        r, e;
        logic [63:0] mask;
        logic        acc_last, prev_stall;
        logic [63:0] prev_sum;
        int          t0;
        mask       = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        acc_last   = 1'b0;
        prev_stall = 1'b0;
        prev_sum   = '0;
        for (int c = 0; c < ncyc + 80; c++) begin
            @(negedge clk);
            if (!(iv[d] && !acc_last)) begin
                iv[d] = 1'b0;
                if (c < ncyc && $urandom_range(0, 3) != 0) begin
                    iv[d]  = 1'b1;
                    md[d]  = $urandom_range(0, 1) == 1;
                    a_s[d] = pick_operand(mask);
                    b_s[d] = pick_operand(mask);
                end
            end
            ordy[d] = (full_rate || c >= ncyc) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk($sformatf("d%0d_hold_valid", d), {63'd0, ov_s[d]}, 64'd1);
                chk($sformatf("d%0d_hold_sum", d), sum_s[d], prev_sum);
            end
            if (full_rate) chk($sformatf("d%0d_full_rate_ready", d), {63'd0, ir_s[d]}, 64'd1);
            acc_last = iv[d] && ir_s[d];
            if (acc_last) begin
                exp_q.push_back(ref_model(w, md[d], a_s[d], b_s[d]));
                t_q.push_back(c);
            end
            if (ov_s[d] && ordy[d]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("d%0d_spurious_output", d), 64'd1, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    t0 = t_q.pop_front();
                    chk($sformatf("d%0d_sum", d), sum_s[d], e.s);
                    chk($sformatf("d%0d_carry", d), {63'd0, co_s[d]}, {63'd0, e.c});
                    chk($sformatf("d%0d_ovf", d), {63'd0, of_s[d]}, {63'd0, e.o});
                    if (full_rate) chk($sformatf("d%0d_latency", d), 64'(c - t0), 64'(stages));
                end
            end
            prev_stall = ov_s[d] && !ordy[d];
            prev_sum   = sum_s[d];
            if (c >= ncyc && exp_q.size() == 0 && !iv[d]) break;
        end
        iv[d] = 1'b0;
        chk($sformatf("d%0d_drained", d), 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [63:0] bp_a[4], bp_b[4], bp_exp[4];
        int          idx, outn, cnt;

        tbl[0] = '{1'b0, 64'h12345678, 64'h87654321, 64'h99999999, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 64'hFFFFFFFF, 64'h00000001, 64'hFFFFFFFE, 1'b1, 1'b0};
`ifdef ADD_SUB_SATURATE_EN
        tbl[2] = '{1'b1, 64'h7FFFFFFF, 64'h80000000, 64'h7FFFFFFF, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 64'h80000000, 64'h80000000, 64'h80000000, 1'b1, 1'b1};
`else
        tbl[2] = '{1'b1, 64'h7FFFFFFF, 64'h80000000, 64'hFFFFFFFF, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 64'h80000000, 64'h80000000, 64'h00000000, 1'b1, 1'b1};
`endif
        tbl[4] = '{1'b1, 64'h00000000, 64'h00000001, 64'hFFFFFFFF, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 64'hFFFFFFFF, 64'h00000001, 64'h00000000, 1'b1, 1'b0};

        bp_a[0] = 64'hAAAAAAAA; bp_b[0] = 64'h55555555; bp_exp[0] = 64'hFFFFFFFF;
        for (int i = 1; i < 4; i++) begin
            bp_a[i] = 64'(i); bp_b[i] = 64'(i); bp_exp[i] = 64'(2 * i);
        end

        idle_all();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), {63'd0, ov_s[d]}, 64'd0);
            chk($sformatf("rst_sum%0d", d), sum_s[d], 64'd0);
        end
        chk("rst_carry", {63'd0, co_s[0]}, 64'd0);
        chk("rst_ovf", {63'd0, of_s[0]}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, ir_s[0]}, 64'd1);

        for (int i = 0; i < 6; i++) send_one(tbl[i], i);

        // Back-pressure: four offered adds, consumer stalled for five cycles.
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ordy[0] = 1'b0; iv[0] = 1'b1; md[0] = 1'b0;
            a_s[0] = bp_a[idx]; b_s[0] = bp_b[idx];
            #1;
            if (ov_s[0]) chk("bp_hold_sum", sum_s[0], 64'hFFFFFFFF);
            if (ir_s[0]) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_in_ready_low", {63'd0, ir_s[0]}, 64'd0);
        chk("bp_out_valid", {63'd0, ov_s[0]}, 64'd1);
        outn = 0;
        for (int c = 0; c < 20 && outn < 4; c++) begin
            @(negedge clk);
            ordy[0] = 1'b1;
            iv[0]   = (idx < 4);
            if (idx < 4) begin a_s[0] = bp_a[idx]; b_s[0] = bp_b[idx]; end
            #1;
            if (iv[0] && ir_s[0]) idx++;
            if (ov_s[0] && ordy[0]) begin
                chk($sformatf("bp_out%0d", outn), sum_s[0], bp_exp[outn]);
                outn++;
            end
        end
        chk("bp_out_count", 64'(outn), 64'd4);
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        chk("bp_no_duplicate", {63'd0, ov_s[0]}, 64'd0);

        // Reset with two transactions in flight.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ordy[0] = 1'b0; iv[0] = 1'b1; md[0] = 1'b0;
            a_s[0] = 64'h11110000 + 64'(c); b_s[0] = 64'h1;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        chk("mid_pre_rst_valid", {63'd0, ov_s[0]}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, ov_s[0]}, 64'd0);
        chk("mid_rst_sum", sum_s[0], 64'd0);
        @(negedge clk);
        rst = 1'b0; ordy[0] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ov_s[0]) cnt++;
        end
        chk("mid_rst_no_output", 64'(cnt), 64'd0);

        run_random(0, 32, 2, 200, 1'b1);
        run_random(0, 32, 2, 300, 1'b0);
        run_random(1, 8, 4, 200, 1'b1);
        run_random(1, 8, 4, 300, 1'b0);
        run_random(2, 64, 1, 200, 1'b1);
        run_random(2, 64, 1, 300, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output.
- Splits the carry chain into STAGES register-separated slices, reaching full clock rate at wide WIDTH.
- Adds carry and signed-overflow flags, plus an optional signed-saturation mode.
- Sits in the datapath wherever the single-cycle adder_subtractor is too slow or needs flow control.

Parameters:
- WIDTH, 32: operand and result width in bits; must be divisible by STAGES.
- STAGES, 2: number of pipeline stages (carry-chain slices); 1..WIDTH; latency = STAGES cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b and mode are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- mode  input  1  0 = a + b, 1 = a - b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- carry_out  output  1  carry from the MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the unsaturated result.

Behaviour:
- Reset: asserting rst clears all stage valid bits asynchronously.
  - out_valid=0, sum=0, carry_out=0, overflow=0. in_ready is 1 once rst deasserts.
  - Reset mid-operation discards all in-flight transactions. Nothing is emitted for them.
- Slicing: SW = WIDTH/STAGES.
  - Subtract is computed as a + ~b + 1; the +1 is the carry-in to slice 0.
  - Stage k computes bits [k*SW +: SW] using the registered carry from stage k-1.
  - Lower result bits and the not-yet-used upper operand bits travel with the transaction.
- Flags: computed in the last stage.
  - carry_out = carry from bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Inputs are held by the source until accepted. Outputs hold stable while out_valid && !out_ready.
- Flow control: stage i loads when it is empty or stage i+1 is loading (bubble-collapsing).
  - in_ready = stage0 empty || stage0 advancing.
  - in_ready depends only on registered state and out_ready; there is no combinational path from in_valid.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
  - Throughput is 1 transaction per cycle. Ordering is preserved.
- Full pipeline with out_ready=0: in_ready=0 and no data is lost.
  - Releasing out_ready drains one transaction per cycle.
  - A simultaneous accept at the input and emit at the output keeps occupancy constant.
- Wrap-around: sum is modulo 2^WIDTH; there is no width growth.
- STAGES=1 degenerates to a single registered adder with the same handshake.

Optional Feature:
- Macro: ADD_SUB_SATURATE_EN.
- Defined: when overflow=1, sum is clamped to the signed extreme.
  - 0x7FF..F if the true result is positive (A's sign bit = 0).
  - 0x800..0 if it is negative.
  - overflow still reports 1; carry_out is unchanged.
- Undefined: sum always wraps; there is no clamp logic.

Decomposition:
- Package add_sub_pkg:
  - mode typedef enum logic {MODE_ADD=1'b0, MODE_SUB=1'b1}.
  - Helper function computing signed-overflow from MSB carries.
- Sub-module add_sub_stage (parametrised by SW):
  - One slice adder plus its stage register and valid bit.
  - Ports: carry in/out, operand slice, pass-through payload, load enable.
  - Instantiated STAGES times in a generate loop.
  - The top-level module holds the handshake logic and flag/saturation logic.

Test Plan:
- Add, WIDTH=32, STAGES=2, out_ready=1: a=0x12345678, b=0x87654321, mode=0 -> after 2 cycles sum=0x99999999, carry_out=0, overflow=0.
- Subtract: a=0xFFFFFFFF, b=0x00000001, mode=1 -> sum=0xFFFFFFFE, carry_out=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x80000000, mode=1.
  - Without the macro: sum=0xFFFFFFFF, carry_out=0, overflow=1.
  - With ADD_SUB_SATURATE_EN: sum=0x7FFFFFFF.
- Back-pressure:
  - Stream 4 back-to-back adds (0xAAAAAAAA+0x55555555 -> 0xFFFFFFFF, then i+i for i=1..3) with out_ready=0 for 5 cycles.
  - Required: in_ready falls after 2 accepts, outputs held stable; after release, results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst while 2 transactions are in flight -> out_valid=0 immediately and sum=0; none of those results ever appear after deassertion.
- Parameter sweep: WIDTH=8, STAGES=4 and WIDTH=64, STAGES=1 with random operands -> every result matches a reference model; latency equals STAGES.
